// File: rtl/timestamp_capture_arbiter_pkg.sv
// Shared helpers for the timestamp capture path: width derivation and
// Gray-to-binary conversion (also used by the FIFO read side).
package timestamp_pkg;

  // Widest timestamp the shared conversion function handles.
  localparam int GRAY_MAX_W = 64;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Requester ID field width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Gray to binary: each binary bit is the XOR of its Gray bit and all
  // bits above it. Computed as a log-step suffix XOR so the function is
  // width-agnostic for zero-extended inputs; callers truncate the result.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < GRAY_MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/timestamp_capture_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward with wrap-around and
// moves the pointer just past the winner whenever a grant is taken.
module rr_arbiter
  import timestamp_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic            adv_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_idx_o,
  output logic            any_o
);

  logic [ID_W-1:0]          ptr_q;
  logic [ID_W-1:0]          ptr_d;
  logic [N-1:0]             mask;
  logic [N-1:0]             hi_req;
  logic [N-1:0]             pick_req;
  logic [N:0]               found;
  logic [N:0][ID_W-1:0]     idx_acc;

  // Requests at or above the pointer win; otherwise fall back to the
  // wrapped-around lower half. A fixed-priority chain then picks the lowest.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask[gi] = (ID_W'(gi) >= ptr_q);
  end

  assign hi_req   = req_i & mask;
  assign pick_req = (|hi_req) ? hi_req : req_i;

  assign found[0]   = 1'b0;
  assign idx_acc[0] = '0;
  for (genvar gi = 0; gi < N; gi++) begin : g_chain
    assign gnt_o[gi]       = pick_req[gi] & ~found[gi];
    assign found[gi+1]     = found[gi] | pick_req[gi];
    assign idx_acc[gi+1]   = idx_acc[gi] | (gnt_o[gi] ? ID_W'(gi) : '0);
  end

  assign any_o     = found[N];
  assign gnt_idx_o = idx_acc[N];

  // Next pointer: one past the winner, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && any_o) begin
      ptr_d = (gnt_idx_o == ID_W'(N - 1)) ? '0 : gnt_idx_o + ID_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/timestamp_capture_arbiter.sv
// Snapshots a shared Gray timestamp counter into per-requester slots and
// serializes the pending snapshots round-robin onto a valid/ready stream.
module timestamp_capture_arbiter
  import timestamp_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int N             = 4,
  parameter int ID_W          = id_width(N),
  parameter int OUTPUT_BINARY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt_gray,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     drop,
  output logic [WIDTH-1:0] m_ts,
  output logic [ID_W-1:0]  m_id,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [N-1:0]           pending_q;
  logic [N-1:0]           pending_d;
  logic [N-1:0]           drop_q;
  logic [N-1:0]           drop_d;
  logic [N-1:0]           cap_req;
  logic [N-1:0]           cap_en;
  logic [N-1:0]           gnt;
  logic [N-1:0]           gnt_take;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_any;
  logic                   out_free;
  logic [N:0][WIDTH-1:0]  sel_acc;
  logic [WIDTH-1:0]       ts_conv;

  logic                   m_valid_q;
  logic                   m_valid_d;
  logic [WIDTH-1:0]       m_ts_q;
  logic [WIDTH-1:0]       m_ts_d;
  logic [ID_W-1:0]        m_id_q;
  logic [ID_W-1:0]        m_id_d;

  // The output register can take a new beat when empty or being drained now.
  assign out_free = ~m_valid_q | m_ready;
  assign cap_req  = {N{enable}} & req;

  rr_arbiter #(
    .N    (N),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (pending_q),
    .adv_i     (out_free),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign gnt_take   = gnt & {N{out_free}};
  assign sel_acc[0] = '0;

  // Per-requester slot. A request is accepted when the slot is free or is
  // being emptied at this very edge; otherwise the old snapshot is kept and
  // the loss is flagged.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_q;

    assign cap_en[gi]      = cap_req[gi] & (~pending_q[gi] | gnt_take[gi]);
    assign pending_d[gi]   = cap_en[gi] | (pending_q[gi] & ~gnt_take[gi]);
    assign drop_d[gi]      = cap_req[gi] & pending_q[gi] & ~gnt_take[gi];
    assign sel_acc[gi+1]   = sel_acc[gi] | (gnt[gi] ? slot_q : '0);

    // Slot snapshot register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else if (cap_en[gi]) begin
        slot_q <= cnt_gray;
      end
    end
  end

  // Conversion sits between the slot mux and the output register.
  if (OUTPUT_BINARY != 0) begin : g_bin
    assign ts_conv = WIDTH'(gray2bin(GRAY_MAX_W'(sel_acc[N])));
  end else begin : g_gray
    assign ts_conv = sel_acc[N];
  end

  // Output register next state: load on grant, clear when drained with
  // nothing to replace it, hold otherwise.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ts_d    = m_ts_q;
    m_id_d    = m_id_q;
    if (out_free) begin
      if (gnt_any) begin
        m_valid_d = 1'b1;
        m_ts_d    = ts_conv;
        m_id_d    = gnt_idx;
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  // Pending flags, drop pulses and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      drop_q    <= '0;
      m_valid_q <= 1'b0;
      m_ts_q    <= '0;
      m_id_q    <= '0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      m_valid_q <= m_valid_d;
      m_ts_q    <= m_ts_d;
      m_id_q    <= m_id_d;
    end
  end

  assign drop    = drop_q;
  assign m_valid = m_valid_q;
  assign m_ts    = m_ts_q;
  assign m_id    = m_id_q;

endmodule

// File: tb/tb_timestamp_capture_arbiter.sv
// Bench for timestamp_capture_arbiter: directed vector table, asynchronous
// reset sequence, then randomized traffic against a queue-level model.
module tb_timestamp_capture_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int NVEC  = 30;
  localparam int NRAND = 3000;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [WIDTH-1:0] cnt_gray;
  logic [N-1:0]     req;
  logic [N-1:0]     drop;
  logic [WIDTH-1:0] m_ts;
  logic [ID_W-1:0]  m_id;
  logic             m_valid;
  logic             m_ready;

  int n_checks;
  int n_fail;

  timestamp_capture_arbiter #(
    .WIDTH         (WIDTH),
    .N             (N),
    .ID_W          (ID_W),
    .OUTPUT_BINARY (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cnt_gray (cnt_gray),
    .req      (req),
    .drop     (drop),
    .m_ts     (m_ts),
    .m_id     (m_id),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic [N-1:0]     req;
    logic             rdy;
    logic [WIDTH-1:0] cnt;
    logic             ev;
    logic [WIDTH-1:0] ets;
    logic [ID_W-1:0]  eid;
    logic [N-1:0]     edrop;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic en, logic [N-1:0] rq, logic rdy, logic [WIDTH-1:0] cnt,
                              logic ev, logic [WIDTH-1:0] ets, logic [ID_W-1:0] eid,
                              logic [N-1:0] edrop);
    vec_t v;
    v.en = en; v.req = rq; v.rdy = rdy; v.cnt = cnt;
    v.ev = ev; v.ets = ets; v.eid = eid; v.edrop = edrop;
    return v;
  endfunction

  // Binary value = XOR of the Gray word with all its right shifts.
  function automatic logic [WIDTH-1:0] g2b(logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: which requesters hold a snapshot, the snapshot
  // values, the next requester to favour, and the output beat.
  bit [N-1:0]       pend_m;
  logic [WIDTH-1:0] slot_m [N];
  int               rr_m;
  bit               ov_m;
  logic [WIDTH-1:0] ots_m;
  int               oid_m;
  logic [N-1:0]     edrop_m;

  task automatic model_reset();
    pend_m = '0;
    for (int i = 0; i < N; i++) slot_m[i] = '0;
    rr_m = 0; ov_m = 1'b0; ots_m = '0; oid_m = 0; edrop_m = '0;
  endtask

  task automatic model_step(input logic en, input logic [N-1:0] rq, input logic rdy,
                            input logic [WIDTH-1:0] cnt);
    bit         free;
    int         g;
    bit [N-1:0] pend_old;
    free     = !ov_m || rdy;
    g        = -1;
    pend_old = pend_m;
    edrop_m  = '0;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr_m + k) % N;
        if (g < 0 && pend_m[j]) g = j;
      end
    end
    if (g >= 0) begin
      ots_m     = g2b(slot_m[g]);
      oid_m     = g;
      ov_m      = 1'b1;
      pend_m[g] = 1'b0;
      rr_m      = (g + 1) % N;
    end else if (free) begin
      ov_m = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (en && rq[i]) begin
        if (!pend_old[i] || i == g) begin
          slot_m[i] = cnt;
          pend_m[i] = 1'b1;
        end else begin
          edrop_m[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] bin_ctr;
    logic [WIDTH-1:0] r_cnt;
    logic [N-1:0]     r_req;
    logic             r_en;
    logic             r_rdy;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = mk(1, 4'b0001, 1, 8'h07, 0, 8'h00, 0, 4'b0000);
    vecs[1]  = mk(1, 4'b0000, 1, 8'h00, 1, 8'h05, 0, 4'b0000);
    vecs[2]  = mk(1, 4'b0000, 1, 8'h00, 0, 8'h00, 0, 4'b0000);
    vecs[3]  = mk(1, 4'b1111, 1, 8'h3F, 0, 8'h00, 0, 4'b0000);
    vecs[4]  = mk(1, 4'b0000, 1, 8'h00, 1, 8'h2A, 1, 4'b0000);
    vecs[5]  = mk(1, 4'b0000, 1, 8'h00, 1, 8'h2A, 2, 4'b0000);
    vecs[6]  = mk(1, 4'b0000, 1, 8'h00, 1, 8'h2A, 3, 4'b0000);
    vecs[7]  = mk(1, 4'b0000, 1, 8'h00, 1, 8'h2A, 0, 4'b0000);
    vecs[8]  = mk(1, 4'b0000, 1, 8'h00, 0, 8'h00, 0, 4'b0000);
    vecs[9]  = mk(1, 4'b0100, 0, 8'h01, 0, 8'h00, 0, 4'b0000);
    vecs[10] = mk(1, 4'b0000, 0, 8'h02, 1, 8'h01, 2, 4'b0000);
    vecs[11] = mk(1, 4'b0100, 0, 8'h03, 1, 8'h01, 2, 4'b0000);
    vecs[12] = mk(1, 4'b0100, 0, 8'h06, 1, 8'h01, 2, 4'b0100);
    vecs[13] = mk(1, 4'b0000, 0, 8'h00, 1, 8'h01, 2, 4'b0000);
    vecs[14] = mk(1, 4'b0000, 1, 8'h00, 1, 8'h02, 2, 4'b0000);
    vecs[15] = mk(1, 4'b0000, 1, 8'h00, 0, 8'h00, 0, 4'b0000);
    vecs[16] = mk(1, 4'b0010, 1, 8'h04, 0, 8'h00, 0, 4'b0000);
    vecs[17] = mk(1, 4'b0010, 1, 8'h05, 1, 8'h07, 1, 4'b0000);
    vecs[18] = mk(1, 4'b0000, 1, 8'h00, 1, 8'h06, 1, 4'b0000);
    vecs[19] = mk(1, 4'b0000, 1, 8'h00, 0, 8'h00, 0, 4'b0000);
    vecs[20] = mk(0, 4'b1111, 1, 8'h11, 0, 8'h00, 0, 4'b0000);
    vecs[21] = mk(0, 4'b1111, 1, 8'h12, 0, 8'h00, 0, 4'b0000);
    vecs[22] = mk(1, 4'b0000, 1, 8'h00, 0, 8'h00, 0, 4'b0000);
    vecs[23] = mk(1, 4'b0011, 1, 8'h08, 0, 8'h00, 0, 4'b0000);
    vecs[24] = mk(1, 4'b0001, 1, 8'h09, 1, 8'h0F, 0, 4'b0000);
    vecs[25] = mk(1, 4'b0010, 1, 8'h0A, 1, 8'h0F, 1, 4'b0000);
    vecs[26] = mk(1, 4'b0001, 1, 8'h0B, 1, 8'h0E, 0, 4'b0000);
    vecs[27] = mk(1, 4'b0000, 1, 8'h00, 1, 8'h0C, 1, 4'b0000);
    vecs[28] = mk(1, 4'b0000, 1, 8'h00, 1, 8'h0D, 0, 4'b0000);
    vecs[29] = mk(1, 4'b0000, 1, 8'h00, 0, 8'h00, 0, 4'b0000);

    // Reset state.
    rst_n = 1'b0; enable = 1'b0; cnt_gray = '0; req = '0; m_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_ts",    32'(m_ts),    32'd0);
    check("rst_id",    32'(m_id),    32'd0);
    check("rst_drop",  32'(drop),    32'd0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      enable = vecs[i].en; req = vecs[i].req; m_ready = vecs[i].rdy; cnt_gray = vecs[i].cnt;
      tick();
      $display("vec %0d: req=%b rdy=%0d -> valid=%0d id=%0d ts=%0h drop=%b",
               i, vecs[i].req, vecs[i].rdy, m_valid, m_id, m_ts, drop);
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_drop", i),  32'(drop),    32'(vecs[i].edrop));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_ts", i), 32'(m_ts), 32'(vecs[i].ets));
        check($sformatf("vec%0d_id", i), 32'(m_id), 32'(vecs[i].eid));
      end
    end

    // Reset while three entries are pending and one beat is held.
    enable = 1'b1; req = 4'b1111; m_ready = 1'b0; cnt_gray = 8'h20;
    tick();
    req = 4'b0000;
    tick();
    $display("pre-reset: valid=%0d id=%0d", m_valid, m_id);
    check("prerst_valid", 32'(m_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%0d drop=%b", m_valid, drop);
    check("async_rst_valid", 32'(m_valid), 32'd0);
    check("async_rst_drop",  32'(drop),    32'd0);
    tick(); tick();
    rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("post-reset %0d: valid=%0d drop=%b", i, m_valid, drop);
      check($sformatf("postrst%0d_valid", i), 32'(m_valid), 32'd0);
      check($sformatf("postrst%0d_drop", i),  32'(drop),    32'd0);
    end

    // Randomized traffic against the model, starting from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    bin_ctr = '0;
    for (int c = 0; c < NRAND; c++) begin
      bin_ctr = bin_ctr + 8'd1;
      r_cnt   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (bin_ctr ^ (bin_ctr >> 1));
      r_req   = 4'($urandom & $urandom);
      r_en    = ($urandom_range(0, 7) != 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      enable = r_en; req = r_req; m_ready = r_rdy; cnt_gray = r_cnt;
      model_step(r_en, r_req, r_rdy, r_cnt);
      tick();
      if (m_valid) $display("rand %0d: beat id=%0d ts=%0h drop=%b", c, m_id, m_ts, drop);
      check($sformatf("rand%0d_valid", c), 32'(m_valid), 32'(ov_m));
      check($sformatf("rand%0d_drop", c),  32'(drop),    32'(edrop_m));
      if (ov_m) begin
        check($sformatf("rand%0d_ts", c), 32'(m_ts), 32'(ots_m));
        check($sformatf("rand%0d_id", c), 32'(m_id), 32'(oid_m));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
